// File: rtl/wb_stage_pkg.sv
// Shared core definitions for the MiniMotorway writeback stage and load path.
package wb_stage_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB payload in, register-file write port / forwarding bus / counters out.
interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             flush;
    logic             in_valid;
    logic             in_reg_write;
    logic [4:0]       in_rd;
    logic [1:0]       in_wb_sel;
    logic [2:0]       in_funct3;
    logic [1:0]       in_addr_lo;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_pc_plus4;
    logic [XLEN-1:0]  in_load_data;

    logic [4:0]       rd;
    logic             reg_write;
    logic [XLEN-1:0]  write_data;
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic             load_fault;
    logic [CNT_W-1:0] instret;

    // Upstream side (memory stage / test driver).
    modport master (
        output flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_addr_lo, in_alu_result, in_pc_plus4, in_load_data,
        input  rd, reg_write, write_data, fwd_valid, fwd_rd, fwd_data,
               load_fault, instret
    );

    // Writeback stage side.
    modport slave (
        input  flush, in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
               in_addr_lo, in_alu_result, in_pc_plus4, in_load_data,
        output rd, reg_write, write_data, fwd_valid, fwd_rd, fwd_data,
               load_fault, instret
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: lane select, sign/zero extension, fault detect.
// Shared with the LSU, so it carries no clock or state.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes out of the aligned word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
    end

    // Extend per load type; misaligned or unknown types fault with zero data.
    always_comb begin
        data  = {XLEN{1'b0}};
        fault = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH: begin
                if (addr_lo[0]) begin
                    fault = 1'b1;
                end else begin
                    data = {{(XLEN-16){half_s[15]}}, half_s};
                end
            end
            F3_LHU: begin
                if (addr_lo[0]) begin
                    fault = 1'b1;
                end else begin
                    data = {{(XLEN-16){1'b0}}, half_s};
                end
            end
            F3_LW: begin
                if (addr_lo != 2'd0) begin
                    fault = 1'b1;
                end else begin
                    data = raw;
                end
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM/WB payload, selects the writeback value,
// drives the regfile write port and forwarding bus, and counts retirements.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 64
) (
    input  logic       clk,
    input  logic       resetn,
    wb_stage_if.slave  bus
);

    logic             cap_s;
    logic [XLEN-1:0]  sel_data_s;
    logic             sel_we_s;
    logic             sel_fault_s;
    logic [XLEN-1:0]  ld_data_s;
    logic             ld_fault_s;

    logic             wb_valid_r;
    logic             wb_fault_r;
    logic [4:0]       wb_rd_r;
    logic [XLEN-1:0]  wb_data_r;
    logic             reg_write_r;
    logic             load_fault_r;
    logic [CNT_W-1:0] instret_r;

    wb_stage_load_align #(.XLEN(XLEN)) u_load_align (
        .funct3  (bus.in_funct3),
        .addr_lo (bus.in_addr_lo),
        .raw     (bus.in_load_data),
        .data    (ld_data_s),
        .fault   (ld_fault_s)
    );

    assign cap_s = bus.in_valid & ~bus.flush;

    // Writeback source mux; the reserved select suppresses the write silently.
    always_comb begin
        sel_data_s  = {XLEN{1'b0}};
        sel_we_s    = 1'b0;
        sel_fault_s = 1'b0;
        case (bus.in_wb_sel)
            WB_SEL_ALU: begin
                sel_data_s = bus.in_alu_result;
                sel_we_s   = bus.in_reg_write;
            end
            WB_SEL_LOAD: begin
                sel_data_s  = ld_data_s;
                sel_we_s    = bus.in_reg_write & ~ld_fault_s;
                sel_fault_s = ld_fault_s;
            end
            WB_SEL_PC4: begin
                sel_data_s = bus.in_pc_plus4;
                sel_we_s   = bus.in_reg_write;
            end
            default: begin
                sel_data_s = {XLEN{1'b0}};
                sel_we_s   = 1'b0;
            end
        endcase
    end

    // MEM/WB pipeline register; payload holds while nothing is captured.
    // The write strobe and fault pulse are precomputed so outputs are flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_r   <= 1'b0;
            wb_fault_r   <= 1'b0;
            wb_rd_r      <= 5'd0;
            wb_data_r    <= {XLEN{1'b0}};
            reg_write_r  <= 1'b0;
            load_fault_r <= 1'b0;
        end else begin
            wb_valid_r   <= cap_s;
            reg_write_r  <= cap_s & sel_we_s & (bus.in_rd != 5'd0);
            load_fault_r <= cap_s & sel_fault_s;
            if (cap_s) begin
                wb_fault_r <= sel_fault_s;
                wb_rd_r    <= bus.in_rd;
                wb_data_r  <= sel_data_s;
            end
        end
    end

    // Retired-instruction counter; faulted loads do not retire, wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (wb_valid_r && !wb_fault_r) begin
            instret_r <= instret_r + CNT_W'(1);
        end
    end

    assign bus.rd         = wb_rd_r;
    assign bus.reg_write  = reg_write_r;
    assign bus.write_data = wb_data_r;
    assign bus.fwd_valid  = reg_write_r;
    assign bus.fwd_rd     = wb_rd_r;
    assign bus.fwd_data   = wb_data_r;
    assign bus.load_fault = load_fault_r;
    assign bus.instret    = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table plus hand-written sequences.
module tb_wb_stage;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_instret = 64'd0;

    wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();

    wb_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] raw;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic        exp_inc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_reg_write  = 1'b0;
        bus.in_rd         = 5'd0;
        bus.in_wb_sel     = 2'd0;
        bus.in_funct3     = 3'd0;
        bus.in_addr_lo    = 2'd0;
        bus.in_alu_result = 32'd0;
        bus.in_pc_plus4   = 32'd0;
        bus.in_load_data  = 32'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.in_valid      = 1'b1;
        bus.in_reg_write  = v.rw;
        bus.in_rd         = v.rd;
        bus.in_wb_sel     = v.sel;
        bus.in_funct3     = v.f3;
        bus.in_addr_lo    = v.alo;
        bus.in_alu_result = v.alu;
        bus.in_pc_plus4   = v.pc4;
        bus.in_load_data  = v.raw;
    endtask

    initial begin
        //           sel   f3      alo   rw    rd     alu           pc4           raw           we    data          flt   inc
        vecs[0]  = '{2'd0, 3'b000, 2'd0, 1'b1, 5'd5,  32'h12345678, 32'h0,        32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1};
        vecs[1]  = '{2'd1, 3'b000, 2'd3, 1'b1, 5'd6,  32'h0,        32'h0,        32'h80FF7F01, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
        vecs[2]  = '{2'd1, 3'b100, 2'd1, 1'b1, 5'd7,  32'h0,        32'h0,        32'h80FF7F01, 1'b1, 32'h0000007F, 1'b0, 1'b1};
        vecs[3]  = '{2'd1, 3'b001, 2'd2, 1'b1, 5'd8,  32'h0,        32'h0,        32'h80FF7F01, 1'b1, 32'hFFFF80FF, 1'b0, 1'b1};
        vecs[4]  = '{2'd1, 3'b101, 2'd0, 1'b1, 5'd9,  32'h0,        32'h0,        32'h80FF7F01, 1'b1, 32'h00007F01, 1'b0, 1'b1};
        vecs[5]  = '{2'd1, 3'b010, 2'd0, 1'b1, 5'd10, 32'h0,        32'h0,        32'h80FF7F01, 1'b1, 32'h80FF7F01, 1'b0, 1'b1};
        vecs[6]  = '{2'd2, 3'b000, 2'd0, 1'b1, 5'd1,  32'hDEAD0000, 32'h00000104, 32'h0,        1'b1, 32'h00000104, 1'b0, 1'b1};
        vecs[7]  = '{2'd1, 3'b010, 2'd1, 1'b1, 5'd11, 32'h0,        32'h0,        32'h80FF7F01, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[8]  = '{2'd1, 3'b011, 2'd0, 1'b1, 5'd12, 32'h0,        32'h0,        32'h80FF7F01, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[9]  = '{2'd1, 3'b001, 2'd1, 1'b1, 5'd13, 32'h0,        32'h0,        32'h80FF7F01, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[10] = '{2'd0, 3'b000, 2'd0, 1'b1, 5'd0,  32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[11] = '{2'd3, 3'b000, 2'd0, 1'b1, 5'd14, 32'h55555555, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[12] = '{2'd1, 3'b100, 2'd2, 1'b1, 5'd15, 32'h0,        32'h0,        32'h80FF7F01, 1'b1, 32'h000000FF, 1'b0, 1'b1};

        drive_idle();
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Reset then idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_reg_write", {63'd0, bus.reg_write}, 64'd0);
            chk("idle_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
            chk("idle_load_fault", {63'd0, bus.load_fault}, 64'd0);
            chk("idle_instret", bus.instret, 64'd0);
        end

        // Vector table: one instruction each, followed by an idle cycle.
        for (int i = 0; i < 13; i++) begin
            drive_vec(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            drive_idle();
            chk($sformatf("v%0d_reg_write", i), {63'd0, bus.reg_write}, {63'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_fwd_valid", i), {63'd0, bus.fwd_valid}, {63'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_load_fault", i), {63'd0, bus.load_fault}, {63'd0, vecs[i].exp_fault});
            chk($sformatf("v%0d_instret_before", i), bus.instret, exp_instret);
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_rd", i), {59'd0, bus.rd}, {59'd0, vecs[i].rd});
                chk($sformatf("v%0d_write_data", i), {32'd0, bus.write_data}, {32'd0, vecs[i].exp_data});
                chk($sformatf("v%0d_fwd_rd", i), {59'd0, bus.fwd_rd}, {59'd0, vecs[i].rd});
                chk($sformatf("v%0d_fwd_data", i), {32'd0, bus.fwd_data}, {32'd0, vecs[i].exp_data});
            end
            @(negedge clk);
            if (vecs[i].exp_inc) exp_instret = exp_instret + 64'd1;
            chk($sformatf("v%0d_instret_after", i), bus.instret, exp_instret);
            chk($sformatf("v%0d_fault_pulse_end", i), {63'd0, bus.load_fault}, 64'd0);
            chk($sformatf("v%0d_idle_no_write", i), {63'd0, bus.reg_write}, 64'd0);
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_data_hold", i), {32'd0, bus.write_data}, {32'd0, vecs[i].exp_data});
            end
        end

        // Flush beats in_valid: no write, no retirement, payload retained.
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.in_reg_write = 1'b1;
        bus.in_rd = 5'd20; bus.in_wb_sel = 2'd0; bus.in_alu_result = 32'hA5A5A5A5;
        @(negedge clk);
        drive_idle();
        chk("flush_reg_write", {63'd0, bus.reg_write}, 64'd0);
        chk("flush_data_hold", {32'd0, bus.write_data}, 64'h00000000000000FF);
        @(negedge clk);
        chk("flush_instret", bus.instret, exp_instret);

        // Back-to-back: two captures on consecutive edges, no bubble.
        bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'd0;
        bus.in_rd = 5'd21; bus.in_alu_result = 32'h11111111;
        @(negedge clk);
        chk("b2b_first_data", {32'd0, bus.write_data}, 64'h0000000011111111);
        chk("b2b_first_rd", {59'd0, bus.rd}, 64'd21);
        bus.in_rd = 5'd22; bus.in_alu_result = 32'h22222222;
        @(negedge clk);
        drive_idle();
        chk("b2b_second_data", {32'd0, bus.write_data}, 64'h0000000022222222);
        chk("b2b_second_we", {63'd0, bus.reg_write}, 64'd1);
        exp_instret = exp_instret + 64'd1;
        chk("b2b_instret_mid", bus.instret, exp_instret);
        @(negedge clk);
        exp_instret = exp_instret + 64'd1;
        chk("b2b_instret_end", bus.instret, exp_instret);

        // Counter wrap from all ones.
        force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.instret_r;
        chk("wrap_preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.in_valid = 1'b1; bus.in_reg_write = 1'b0; bus.in_wb_sel = 2'd0; bus.in_rd = 5'd3;
        @(negedge clk);
        drive_idle();
        chk("wrap_hold", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap_zero", bus.instret, 64'd0);

        // Asynchronous reset during a pending write.
        bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_wb_sel = 2'd0;
        bus.in_rd = 5'd4; bus.in_alu_result = 32'h0BADBEEF;
        @(posedge clk);
        #1;
        drive_idle();
        chk("pre_reset_write", {63'd0, bus.reg_write}, 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_reset_write", {63'd0, bus.reg_write}, 64'd0);
        chk("async_reset_data", {32'd0, bus.write_data}, 64'd0);
        chk("async_reset_instret", bus.instret, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_instret", bus.instret, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
